// File: rtl/breath_led_multi.sv
// Multi-channel breathing LED driver: one shared tick/frame/triangle-duty timebase
// feeds CH_NUM channels, each independently off, on, breathing or inverted breathing.
module breath_led_multi #(
    parameter int   CNT_2US_MAX = 100,
    parameter int   CNT_2MS_MAX = 1000,
    parameter int   CH_NUM      = 4,
    parameter logic LED_ACTIVE  = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [2*CH_NUM-1:0]   mode,
    input  logic                  sync,
    output logic [CH_NUM-1:0]     led,
    output logic                  frame_tick
);

    localparam int W_US = $clog2(CNT_2US_MAX + 1);
    localparam int W_MS = $clog2(CNT_2MS_MAX + 1);

    logic [W_US-1:0]       cnt_2us_r;
    logic [W_MS-1:0]       cnt_2ms_r;
    logic [W_MS-1:0]       duty_r;
    logic                  dir_up_r;
    logic [2*CH_NUM-1:0]   mode_r;
    logic [CH_NUM-1:0]     led_r;
    logic                  frame_tick_r;

    logic                  tick_s;
    logic                  frame_end_s;
    logic [W_MS-1:0]       inv_duty_s;
    logic [CH_NUM-1:0]     lit_s;

    assign tick_s      = (cnt_2us_r == W_US'(CNT_2US_MAX - 1));
    assign frame_end_s = tick_s && (cnt_2ms_r == W_MS'(CNT_2MS_MAX - 1));
    assign inv_duty_s  = W_MS'(CNT_2MS_MAX) - duty_r;

    // Clock prescaler producing one tick per CNT_2US_MAX cycles
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_2us_r <= {W_US{1'b0}};
        end else if (sync || tick_s) begin
            cnt_2us_r <= {W_US{1'b0}};
        end else begin
            cnt_2us_r <= cnt_2us_r + W_US'(1);
        end
    end

    // PWM frame position, advancing once per tick
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_2ms_r <= {W_MS{1'b0}};
        end else if (sync || frame_end_s) begin
            cnt_2ms_r <= {W_MS{1'b0}};
        end else if (tick_s) begin
            cnt_2ms_r <= cnt_2ms_r + W_MS'(1);
        end else begin
            cnt_2ms_r <= cnt_2ms_r;
        end
    end

    // Triangle duty ramp; sync outranks frame_end so no step happens on a restart
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            duty_r   <= {W_MS{1'b0}};
            dir_up_r <= 1'b1;
        end else if (sync) begin
            duty_r   <= {W_MS{1'b0}};
            dir_up_r <= 1'b1;
        end else if (frame_end_s) begin
            if (dir_up_r) begin
                duty_r <= duty_r + W_MS'(1);
                if (duty_r == W_MS'(CNT_2MS_MAX - 1)) begin
                    dir_up_r <= 1'b0;
                end else begin
                    dir_up_r <= 1'b1;
                end
            end else begin
                duty_r <= duty_r - W_MS'(1);
                if (duty_r == W_MS'(1)) begin
                    dir_up_r <= 1'b1;
                end else begin
                    dir_up_r <= 1'b0;
                end
            end
        end else begin
            duty_r   <= duty_r;
            dir_up_r <= dir_up_r;
        end
    end

    // Mode capture only at frame boundaries so a frame is never cut short
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_r <= {(2*CH_NUM){1'b0}};
        end else if (sync || frame_end_s) begin
            mode_r <= mode;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Per-channel lit decision from the captured mode and the PWM compare
    always_comb begin
        lit_s = {CH_NUM{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            case (mode_r[2*i +: 2])
                2'b00:   lit_s[i] = 1'b0;
                2'b01:   lit_s[i] = 1'b1;
                2'b10:   lit_s[i] = (cnt_2ms_r < duty_r);
                2'b11:   lit_s[i] = (cnt_2ms_r < inv_duty_s);
                default: lit_s[i] = 1'b0;
            endcase
        end
    end

    // Registered pin drive and frame-start strobe
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_r        <= {CH_NUM{~LED_ACTIVE}};
            frame_tick_r <= 1'b0;
        end else begin
            led_r        <= lit_s ^ {CH_NUM{~LED_ACTIVE}};
            frame_tick_r <= frame_end_s || sync;
        end
    end

    assign led        = led_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_breath_led_multi.sv
// Directed bench for breath_led_multi at 10x10 timebase: 100-cycle frames, 20-frame ramp.
module tb_breath_led_multi;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] mode;
    logic       sync;
    logic [3:0] led;
    logic       frame_tick;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [7:0] mode;
        int         duty;
    } vec_t;

    vec_t tbl [21];

    localparam logic [7:0] MODE_A = 8'b01_00_11_10;
    localparam logic [7:0] MODE_B = 8'b00_01_10_11;

    breath_led_multi #(
        .CNT_2US_MAX (10),
        .CNT_2MS_MAX (10),
        .CH_NUM      (4),
        .LED_ACTIVE  (1'b1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .mode       (mode),
        .sync       (sync),
        .led        (led),
        .frame_tick (frame_tick)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lit(input logic [1:0] m, input int d);
        case (m)
            2'b00:   return 0;
            2'b01:   return 100;
            2'b10:   return 10 * d;
            default: return 100 - 10 * d;
        endcase
    endfunction

    // Measure one frame window, starting at a negedge where frame_tick is high.
    task automatic run_frame(input logic [7:0] cur_mode, input int d,
                             input logic [7:0] next_mode, input int sync_at);
        int cnt [4];
        bit synced;
        cnt    = '{0, 0, 0, 0};
        synced = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            @(negedge sys_clk);
            for (int c = 0; c < 4; c++) if (led[c]) cnt[c]++;
            if (j == 40) mode = next_mode;
            if (synced) begin
                sync = 1'b0;
                if (j < 100) begin
                    check(frame_tick == 1'b1, "sync_tick", int'(frame_tick), 1);
                    return;
                end
            end
            if (j == sync_at) begin
                sync   = 1'b1;
                synced = 1'b1;
            end
        end
        check(frame_tick == 1'b1, $sformatf("frame_len_d%0d", d), int'(frame_tick), 1);
        for (int c = 0; c < 4; c++) begin
            check(cnt[c] == exp_lit(cur_mode[2*c +: 2], d),
                  $sformatf("lit_ch%0d_d%0d", c, d), cnt[c], exp_lit(cur_mode[2*c +: 2], d));
        end
    endtask

    initial begin
        int duty_list [21];
        int post_duty [13];
        int k;
        int bad;

        duty_list = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        post_duty = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 9, 8, 7};
        for (int r = 0; r < 21; r++) begin
            tbl[r].mode = (r < 11) ? MODE_A : MODE_B;
            tbl[r].duty = duty_list[r];
        end

        tests_run    = 0;
        tests_failed = 0;
        sys_rst_n    = 1'b0;
        mode         = 8'hFF;
        sync         = 1'b0;

        // Reset state and first frame_tick latency
        repeat (10) @(negedge sys_clk);
        check(led == 4'b0000, "reset_led", int'(led), 0);
        check(frame_tick == 1'b0, "reset_ft", int'(frame_tick), 0);
        sys_rst_n = 1'b1;
        k   = 0;
        bad = 0;
        while (k < 200) begin
            @(negedge sys_clk);
            k++;
            if (led != 4'b0000) bad++;
            if (frame_tick) break;
        end
        check(k == 100, "first_frame_tick", k, 100);
        check(bad == 0, "dark_before_first_frame", bad, 0);

        // Steady mode on ch0
        sys_rst_n = 1'b0;
        mode      = 8'b00_00_00_01;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        k = 0;
        while (k < 200) begin
            @(negedge sys_clk);
            k++;
            if (frame_tick) break;
        end
        check(k == 100, "steady_first_tick", k, 100);
        check(led == 4'b0000, "steady_led_at_tick", int'(led), 0);
        @(negedge sys_clk);
        check(led == 4'b0001, "steady_led_after_tick", int'(led), 1);
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            if (led != 4'b0001) bad++;
        end
        check(bad == 0, "steady_2000_cycles", bad, 0);

        // Table-driven ramp after a sync; mode switches at cycle 40 of row 10
        @(negedge sys_clk);
        mode = tbl[0].mode;
        sync = 1'b1;
        @(negedge sys_clk);
        sync = 1'b0;
        check(frame_tick == 1'b1, "sync_start_tick", int'(frame_tick), 1);
        for (int r = 0; r < 21; r++) begin
            run_frame(tbl[r].mode, tbl[r].duty, tbl[(r < 20) ? r + 1 : 20].mode, -1);
        end

        // Continue into the down ramp, then sync mid-frame at duty 6
        for (int r = 0; r < 13; r++) begin
            run_frame(MODE_B, post_duty[r], MODE_B, -1);
        end
        run_frame(MODE_B, 6, MODE_B, 30);
        run_frame(MODE_B, 0, MODE_B, -1);
        // sync coincident with frame_end must not let duty step
        run_frame(MODE_B, 1, MODE_B, 99);
        run_frame(MODE_B, 0, MODE_B, -1);
        run_frame(MODE_B, 1, MODE_B, -1);

        // Asynchronous reset in the middle of a duty-2 frame
        repeat (37) @(negedge sys_clk);
        check(led == 4'b0101, "pre_reset_led", int'(led), 5);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check(led == 4'b0000, "async_reset_led", int'(led), 0);
        check(frame_tick == 1'b0, "async_reset_ft", int'(frame_tick), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
